// File: rtl/triangle_assembler_pkg.sv
// Shared graphics types for the triangle assembly path (package graphics_pkg).
package graphics_pkg;

  typedef logic [3:0][31:0] vertex_t;
  typedef logic [11:0]      color_t;

  typedef struct packed {
    vertex_t [2:0] v;
    color_t        color;
  } triangle_t;

  localparam int TRI_VERTS = 3;

  typedef enum logic [1:0] {
    COLLECT0 = 2'd0,
    COLLECT1 = 2'd1,
    COLLECT2 = 2'd2
  } assembler_state_t;

  // Position-only equality: word 3 carries no geometry and is ignored.
  function automatic logic xyz_equal(input vertex_t a, input vertex_t b);
    return (a[2:0] == b[2:0]);
  endfunction

endpackage

// File: rtl/tri_degenerate_check.sv
// Flags a triangle with two coincident vertices; only built with TRIANGLE_ASSEMBLER_CULL_EN.
`ifdef TRIANGLE_ASSEMBLER_CULL_EN
module tri_degenerate_check
  import graphics_pkg::*;
(
  input  vertex_t i_v0,
  input  vertex_t i_v1,
  input  vertex_t i_v2,
  output logic    o_degenerate
);

  assign o_degenerate = xyz_equal(i_v0, i_v1) || xyz_equal(i_v0, i_v2) || xyz_equal(i_v1, i_v2);

endmodule
`endif

// File: rtl/triangle_assembler.sv
// Groups three accepted vertices into one registered triangle record.
// Optional degenerate-triangle culling is enabled by TRIANGLE_ASSEMBLER_CULL_EN.
module triangle_assembler
  import graphics_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic [3:0][31:0]        vertex_in,
  input  logic [11:0]             color_in,
  input  logic                    flush_in,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic [2:0][3:0][31:0]   tri_out,
  output logic [11:0]             color_out,
`ifdef TRIANGLE_ASSEMBLER_CULL_EN
  output logic [CNT_W-1:0]        cull_count_out,
`endif
  output logic [CNT_W-1:0]        tri_count_out
);

  assembler_state_t r_state;
  assembler_state_t w_next_state;
  vertex_t          r_hold0;
  vertex_t          r_hold1;
  color_t           r_hold_color;
  triangle_t        r_out;
  logic             r_valid;
  logic [CNT_W-1:0] r_tri_cnt;

  logic w_accept;
  logic w_store;
  logic w_complete;
  logic w_degenerate;
  logic w_load;
  logic w_handshake;

  // Vertex 2 is the only one that needs the output slot to be free.
  assign ready_out   = (r_state != COLLECT2) || !r_valid || ready_in;
  assign w_accept    = valid_in && ready_out;
  assign w_store     = w_accept && !flush_in;
  assign w_complete  = w_store && (r_state == COLLECT2);
  assign w_load      = w_complete && !w_degenerate;
  assign w_handshake = r_valid && ready_in;

`ifdef TRIANGLE_ASSEMBLER_CULL_EN
  logic [CNT_W-1:0] r_cull_cnt;

  tri_degenerate_check u_degen (
    .i_v0         (r_hold0),
    .i_v1         (r_hold1),
    .i_v2         (vertex_in),
    .o_degenerate (w_degenerate)
  );

  // Count triangles dropped as degenerate.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cull_cnt <= {CNT_W{1'b0}};
    end else if (w_complete && w_degenerate) begin
      r_cull_cnt <= r_cull_cnt + CNT_W'(1);
    end
  end

  assign cull_count_out = r_cull_cnt;
`else
  assign w_degenerate = 1'b0;
`endif

  // Collection state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= COLLECT0;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next collection index; flush overrides any vertex accepted this cycle.
  always_comb begin
    w_next_state = r_state;
    if (flush_in) begin
      w_next_state = COLLECT0;
    end else if (w_accept) begin
      case (r_state)
        COLLECT0: w_next_state = COLLECT1;
        COLLECT1: w_next_state = COLLECT2;
        COLLECT2: w_next_state = COLLECT0;
        default:  w_next_state = COLLECT0;
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  // Holding registers, output record and handoff counter.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_hold0      <= '0;
      r_hold1      <= '0;
      r_hold_color <= 12'h000;
      r_out        <= '0;
      r_valid      <= 1'b0;
      r_tri_cnt    <= {CNT_W{1'b0}};
    end else begin
      if (w_store && (r_state == COLLECT0)) begin
        r_hold0      <= vertex_in;
        r_hold_color <= color_in;
      end
      if (w_store && (r_state == COLLECT1)) begin
        r_hold1 <= vertex_in;
      end
      if (w_load) begin
        r_out.v[0]  <= r_hold0;
        r_out.v[1]  <= r_hold1;
        r_out.v[2]  <= vertex_in;
        r_out.color <= r_hold_color;
      end
      // A load in the handshake cycle keeps valid high: no bubble.
      if (w_load) begin
        r_valid <= 1'b1;
      end else if (w_handshake) begin
        r_valid <= 1'b0;
      end
      if (w_handshake) begin
        r_tri_cnt <= r_tri_cnt + CNT_W'(1);
      end
    end
  end

  assign valid_out     = r_valid;
  assign tri_out       = r_out.v;
  assign color_out     = r_out.color;
  assign tri_count_out = r_tri_cnt;

endmodule

// File: tb/tb_triangle_assembler.sv
// Scoreboard bench for triangle_assembler: a default-width instance plus a CNT_W=2 instance for wrap.
module tb_triangle_assembler;
  import graphics_pkg::*;

  logic                  clk_in;
  logic                  rst_in;
  logic                  valid_in;
  logic                  flush_in;
  logic                  ready_in;
  vertex_t               vertex_in;
  color_t                color_in;

  logic                  ready_out,   ready_out_w;
  logic                  valid_out,   valid_out_w;
  logic [2:0][3:0][31:0] tri_out,     tri_out_w;
  color_t                color_out,   color_out_w;
  logic [15:0]           tri_count_out;
  logic [1:0]            tri_count_w;
`ifdef TRIANGLE_ASSEMBLER_CULL_EN
  logic [15:0]           cull_count_out;
  logic [1:0]            cull_count_w;
`endif

  triangle_assembler #(.CNT_W(16)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
    .vertex_in(vertex_in), .color_in(color_in), .flush_in(flush_in),
    .valid_out(valid_out), .ready_in(ready_in), .tri_out(tri_out), .color_out(color_out),
`ifdef TRIANGLE_ASSEMBLER_CULL_EN
    .cull_count_out(cull_count_out),
`endif
    .tri_count_out(tri_count_out)
  );

  triangle_assembler #(.CNT_W(2)) u_dut_w (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out_w),
    .vertex_in(vertex_in), .color_in(color_in), .flush_in(flush_in),
    .valid_out(valid_out_w), .ready_in(ready_in), .tri_out(tri_out_w), .color_out(color_out_w),
`ifdef TRIANGLE_ASSEMBLER_CULL_EN
    .cull_count_out(cull_count_w),
`endif
    .tri_count_out(tri_count_w)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int        n_checks = 0;
  int        n_fail   = 0;
  triangle_t exp_q[$];
  triangle_t mon_e;
  int        exp_cnt = 0;
  int        m_idx   = 0;
  int        m_cull  = 0;
  vertex_t   m_h0, m_h1;
  color_t    m_hc;
  vertex_t   vs[0:15];
  int        cyc;

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vertex_t mkv(input int k);
    vertex_t v;
    v[3] = 32'hA0000000 + 32'(k);
    v[2] = 32'h3F800000 + 32'(k);
    v[1] = 32'h40000000 + 32'(k);
    v[0] = 32'h40400000 + 32'(k);
    return v;
  endfunction

  function automatic color_t mkc(input int k);
    return 12'(32'h111 * (k + 1));
  endfunction

  function automatic logic degen(input vertex_t a, input vertex_t b, input vertex_t c);
    return (a[2:0] == b[2:0]) || (a[2:0] == c[2:0]) || (b[2:0] == c[2:0]);
  endfunction

  // Reference: collect accepted vertices and queue the triangle each third one completes.
  task automatic model_accept(input vertex_t v, input color_t c, input logic fl);
    triangle_t t;
    if (fl) begin
      m_idx = 0;
    end else if (m_idx == 0) begin
      m_h0 = v; m_hc = c; m_idx = 1;
    end else if (m_idx == 1) begin
      m_h1 = v; m_idx = 2;
    end else begin
      m_idx = 0;
      t.v[0] = m_h0; t.v[1] = m_h1; t.v[2] = v; t.color = m_hc;
`ifdef TRIANGLE_ASSEMBLER_CULL_EN
      if (degen(m_h0, m_h1, v)) m_cull++;
      else exp_q.push_back(t);
`else
      exp_q.push_back(t);
`endif
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send(input vertex_t v, input color_t c, input logic fl, output int cycles);
    logic acc;
    acc = 1'b0;
    cycles = 0;
    valid_in = 1'b1; vertex_in = v; color_in = c; flush_in = fl;
    while (!acc && cycles < 64) begin
      @(negedge clk_in);
      acc = ready_out;
      @(posedge clk_in);
      #1;
      cycles++;
    end
    valid_in = 1'b0; flush_in = 1'b0;
    if (acc) model_accept(v, c, fl);
    else chk("accept_timeout", 384'(0), 384'(1));
  endtask

  task automatic sendk(input int k);
    int c;
    send(vs[k], mkc(k), 1'b0, c);
  endtask

  // Monitor: every handshake must match the oldest expected triangle.
  always @(negedge clk_in) begin
    if (rst_in && valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_triangle", 384'(tri_out), 384'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("tri_out", tri_out, mon_e.v);
        chk("color_out", 384'(color_out), 384'(mon_e.color));
        chk("tri_out_w", tri_out_w, mon_e.v);
        chk("color_out_w", 384'(color_out_w), 384'(mon_e.color));
      end
      chk("valid_out_w", 384'(valid_out_w), 384'(1));
      chk("tri_count", 384'(tri_count_out), 384'(exp_cnt));
      chk("tri_count_w", 384'(tri_count_w), 384'(exp_cnt % 4));
      exp_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) vs[i] = mkv(i);
    vs[0] = {32'hAAAAAAAA, 32'h3F000000, 32'h42200000, 32'h43200000};
    rst_in = 1'b0; valid_in = 1'b0; flush_in = 1'b0; ready_in = 1'b1;
    vertex_in = '0; color_in = 12'h000;
    #2;
    chk("rst_valid", 384'(valid_out), 384'(0));
    chk("rst_tri", tri_out, 384'(0));
    chk("rst_color", 384'(color_out), 384'(0));
    chk("rst_count", 384'(tri_count_out), 384'(0));
    chk("rst_ready", 384'(ready_out), 384'(1));
    #10 rst_in = 1'b1;
    idle(1);

    // Streaming: six vertices back to back, downstream always ready.
    for (int k = 0; k < 6; k++) begin
      send(vs[k], mkc(k), 1'b0, cyc);
      chk("stream_ready", 384'(cyc), 384'(1));
      chk("stream_ready_w", 384'(ready_out_w), 384'(1));
      if (k == 1) chk("pre_latency_valid", 384'(valid_out), 384'(0));
      if (k == 2) chk("latency_valid", 384'(valid_out), 384'(1));
    end
    idle(3);
    chk("stream_count", 384'(tri_count_out), 384'(2));
    chk("stream_idle", 384'(valid_out), 384'(0));

    // Backpressure: first triangle stalls, vertices 0/1 still accepted, vertex 2 waits.
    sendk(6); sendk(7); sendk(8);
    ready_in = 1'b0;
    send(vs[9], mkc(9), 1'b0, cyc);
    chk("bp_v3_cycles", 384'(cyc), 384'(1));
    send(vs[10], mkc(10), 1'b0, cyc);
    chk("bp_v4_cycles", 384'(cyc), 384'(1));
    chk("bp_ready_low", 384'(ready_out), 384'(0));
    idle(2);
    chk("bp_stable_tri", tri_out, exp_q[0].v);
    chk("bp_stable_valid", 384'(valid_out), 384'(1));
    fork
      send(vs[11], mkc(11), 1'b0, cyc);
      begin
        idle(2);
        ready_in = 1'b1;
      end
    join
    chk("bp_no_bubble", 384'(valid_out), 384'(1));
    chk("bp_new_tri", tri_out, exp_q[0].v);
    chk("bp_count_once", 384'(tri_count_out), 384'(3));
    idle(2);
    chk("bp_count_after", 384'(tri_count_out), 384'(4));

    // Flush with a vertex offered in the same cycle: vertex discarded, no triangle.
    sendk(0); sendk(1);
    send(vs[2], mkc(2), 1'b1, cyc);
    idle(3);
    chk("flush_no_tri", 384'(valid_out), 384'(0));
    chk("flush_count", 384'(tri_count_out), 384'(4));
    sendk(3); sendk(4); sendk(5);
    idle(3);
    chk("flush_one_tri", 384'(tri_count_out), 384'(5));

    // Asynchronous reset between clock edges with two vertices collected.
    sendk(6); sendk(7);
    #1 rst_in = 1'b0;
    #1;
    chk("amid_valid", 384'(valid_out), 384'(0));
    chk("amid_count", 384'(tri_count_out), 384'(0));
    chk("amid_count_w", 384'(tri_count_w), 384'(0));
    chk("amid_tri", tri_out, 384'(0));
    m_idx = 0; exp_q.delete(); exp_cnt = 0; m_cull = 0;
    #1 rst_in = 1'b1;
    sendk(8); sendk(9); sendk(10);
    idle(3);
    chk("post_rst_count", 384'(tri_count_out), 384'(1));

    // Wrap of the 2-bit counter across four more triangles.
    for (int t = 0; t < 4; t++) begin
      sendk(t * 3); sendk(t * 3 + 1); sendk(t * 3 + 2);
    end
    idle(3);
    chk("wrap_count_w", 384'(tri_count_w), 384'(1));
    chk("wrap_count", 384'(tri_count_out), 384'(5));

`ifdef TRIANGLE_ASSEMBLER_CULL_EN
    begin
      vertex_t vd;
      vd = vs[11];
      vd[3] = vd[3] ^ 32'hFFFF0000;
      sendk(10); sendk(11);
      send(vd, mkc(12), 1'b0, cyc);
      idle(3);
      chk("cull_no_valid", 384'(valid_out), 384'(0));
      chk("cull_count", 384'(cull_count_out), 384'(m_cull));
      chk("cull_count_one", 384'(cull_count_out), 384'(1));
      chk("cull_count_w", 384'(cull_count_w), 384'(1));
      sendk(12); sendk(13); sendk(14);
      idle(3);
      chk("cull_fwd_count", 384'(tri_count_out), 384'(6));
    end
`endif

    idle(2);
    chk("drained", 384'(exp_q.size()), 384'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
